// File: rtl/fifo1.sv
// fifo1: single-clock first-in first-out buffer of 2**ASIZE words x DSIZE bits.
// Write-increment / read-increment handshake, first-word fall-through read
// data, registered full/empty flags and occupancy count.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst    - synchronous active-high reset
//   wdata  - write data, captured when a write is accepted
//   winc   - write request (accepted when not full)
//   wfull  - FIFO full (registered)
//   rinc   - read request (accepted when not empty)
//   rdata  - word at the head of the FIFO (combinational, valid when !rempty)
//   rempty - FIFO empty (registered)
//   count  - number of stored words, 0..2**ASIZE (registered)
module fifo1 #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic [ASIZE:0]   count
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned PW    = ASIZE + 1;

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          wfull_q, wfull_d;
    logic          rempty_q, rempty_d;
    logic          we, re;

    // Accept logic, next-state pointers, and flags derived from next-state pointers
    always_comb begin
        we       = winc & ~wfull_q;
        re       = rinc & ~rempty_q;
        wptr_d   = wptr_q + PW'(we);
        rptr_d   = rptr_q + PW'(re);
        // Equal pointers mean empty; equal addresses with differing wrap bits mean full
        rempty_d = (wptr_d == rptr_d);
        wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                   (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
        count_d  = wptr_d - rptr_d;
    end

    // Pointer and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    // Storage array, not reset; writes are suppressed while in reset
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    // First-word fall-through head data
    assign rdata  = mem_q[rptr_q[ASIZE-1:0]];
    assign wfull  = wfull_q;
    assign rempty = rempty_q;
    assign count  = count_q;

endmodule

// File: tb/tb_fifo1.sv
module tb_fifo1;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned ASIZE = 4;
    localparam int unsigned DEPTH = 1 << ASIZE;

    logic             clk;
    logic             rst;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic [ASIZE:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored words
    logic [DSIZE-1:0] mq[$];
    int               accepted_writes = 0;

    fifo1 #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .winc   (winc),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             r;
        logic             w;
        logic             rd;
        logic [DSIZE-1:0] d;
        logic             e_empty;
        logic             e_full;
        logic [ASIZE:0]   e_count;
        logic             chk_rd;
        logic [DSIZE-1:0] e_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs against it
    task automatic step(input logic r, input logic w, input logic rd, input logic [DSIZE-1:0] d);
        bit do_w, do_r;
        rst   = r;
        winc  = w;
        rinc  = rd;
        wdata = d;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
        end else begin
            do_w = w && (mq.size() < DEPTH);
            do_r = rd && (mq.size() > 0);
            if (do_r) void'(mq.pop_front());
            if (do_w) begin
                mq.push_back(d);
                accepted_writes++;
            end
        end
        chk("model_empty", 32'(rempty), 32'(mq.size() == 0));
        chk("model_full",  32'(wfull),  32'(mq.size() == DEPTH));
        chk("model_count", 32'(count),  32'(mq.size()));
        if (mq.size() > 0) chk("model_rdata", 32'(rdata), 32'(mq[0]));
    endtask

    initial begin
        logic [DSIZE-1:0] full_words[16];
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;

        // Reset and basic ordering: {rst,winc,rinc,wdata, empty,full,count, chk_rd,rdata}
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 5'd2, 1'b1, 8'hA5};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 5'd3, 1'b1, 8'hA5};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 5'd4, 1'b1, 8'hA5};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd3, 1'b1, 8'h5A};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 1'b1, 8'h3C};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'hC3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].d);
            chk($sformatf("vec%0d_empty", i), 32'(rempty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_full", i),  32'(wfull),  32'(vecs[i].e_full));
            chk($sformatf("vec%0d_count", i), 32'(count),  32'(vecs[i].e_count));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
        end

        // Fill to full, then an ignored 17th write
        full_words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                       8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, full_words[i]);
        chk("full_flag", 32'(wfull), 32'd1);
        chk("full_count", 32'(count), 32'd16);
        step(1'b0, 1'b1, 1'b0, 8'h99);
        chk("full_ignore_count", 32'(count), 32'd16);
        chk("full_ignore_head", 32'(rdata), 32'h12);

        // Drain from full
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain_full_drop", 32'(wfull), 32'd0);
        chk("drain_first_next", 32'(rdata), 32'h34);
        for (int i = 1; i < 15; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain_last_word", 32'(rdata), 32'h88);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain_empty", 32'(rempty), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain_extra_count", 32'(count), 32'd0);
        // A fresh write after over-reading must appear at the head
        step(1'b0, 1'b1, 1'b0, 8'h5E);
        chk("after_overread_head", 32'(rdata), 32'h5E);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous read/write with 3 stored
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b1, 1'b0, 8'h03);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
            chk("simul_count", 32'(count), 32'd3);
        end
        chk("simul_head", 32'(rdata), 32'h12);

        // Simultaneous when full: read only
        while (mq.size() < DEPTH) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        chk("simul_full_count", 32'(count), 32'd15);

        // Simultaneous when empty: write only
        while (mq.size() > 0) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hBB);
        chk("simul_empty_count", 32'(count), 32'd1);
        chk("simul_empty_head", 32'(rdata), 32'hBB);

        // Random streaming with a mid-stream reset at occupancy 7
        accepted_writes = 0;
        for (int c = 0; c < 2000 && accepted_writes < 20; c++)
            step(1'b0, 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50), 8'($urandom));
        for (int c = 0; c < 40 && mq.size() != 7; c++) begin
            if (mq.size() < 7) step(1'b0, 1'b1, 1'b0, 8'($urandom));
            else               step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("pre_reset_count", 32'(count), 32'd7);
        step(1'b1, 1'b1, 1'b1, 8'h77);
        chk("midreset_empty", 32'(rempty), 32'd1);
        chk("midreset_count", 32'(count), 32'd0);
        accepted_writes = 0;
        for (int c = 0; c < 2000 && accepted_writes < 40; c++)
            step(1'b0, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom));
        chk("stream_writes", 32'(accepted_writes >= 40), 32'd1);
        while (mq.size() > 0) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("final_empty", 32'(rempty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
